// File: rtl/jtdd_mcu_romfetch.sv
// MCU program-ROM fetch stage: direct-mapped 16-bit word cache in front of SDRAM.
// Hits return in the same cycle; misses run a single req/ack/valid refill.
module jtdd_mcu_romfetch #(
    parameter int IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rom_cs,
    input  logic [13:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_ok,
    input  logic        flush,
    output logic        sdram_req,
    output logic [12:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_valid,
    input  logic [15:0] sdram_data
);
    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 13 - IDX_W;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                 r_st;
    logic                   r_discard;
    logic [N-1:0]           r_valid;
    logic [15:0]            r_data [N];
    logic [TAG_W-1:0]       r_tag  [N];

    logic [IDX_W-1:0]       w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_fidx;
    logic                   w_ret;
    logic                   w_fill;

    assign w_idx    = rom_addr[IDX_W:1];
    assign w_tag    = rom_addr[13:IDX_W+1];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign rom_ok   = rom_cs && w_hit && !flush;
    assign rom_data = rom_addr[0] ? r_data[w_idx][15:8] : r_data[w_idx][7:0];

    // Fill target comes from the latched address, not the live MCU address
    assign w_fidx = sdram_addr[IDX_W-1:0];
    assign w_ret  = (r_st == WAIT && sdram_valid) ||
                    (r_st == REQ && sdram_ack && sdram_valid);
    assign w_fill = w_ret && !r_discard && !flush;

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_fidx] <= sdram_data;
            r_tag[w_fidx]  <= sdram_addr[12:IDX_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st       <= IDLE;
            r_discard  <= 1'b0;
            r_valid    <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            if (flush)       r_valid         <= '0;
            else if (w_fill) r_valid[w_fidx] <= 1'b1;

            case (r_st)
                IDLE: begin
                    r_discard <= 1'b0;
                    if (rom_cs && !w_hit && !flush) begin
                        r_st       <= REQ;
                        sdram_req  <= 1'b1;
                        sdram_addr <= rom_addr[13:1];
                    end
                end
                REQ: begin
                    if (flush) r_discard <= 1'b1;
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        r_st      <= sdram_valid ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (flush) r_discard <= 1'b1;
                    if (sdram_valid) r_st <= IDLE;
                end
                default: begin
                    r_st      <= IDLE;
                    sdram_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtdd_mcu_romfetch.sv
// Directed bench for jtdd_mcu_romfetch with a scoreboard of expected SDRAM fills.
module tb_jtdd_mcu_romfetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_cs = 1'b0;
    logic [13:0] rom_addr = '0;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        flush = 1'b0;
    logic        sdram_req;
    logic [12:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        sdram_valid = 1'b0;
    logic [15:0] sdram_data = '0;

    jtdd_mcu_romfetch #(.IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok), .flush(flush),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .sdram_valid(sdram_valid), .sdram_data(sdram_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] a;
        logic [15:0] d;
    } fill_t;
    fill_t sb[$];

    int checks = 0;
    int errors = 0;
    int req_pulses = 0;
    logic req_q = 1'b0;

    always @(posedge clk) begin
        if (sdram_req && !req_q) req_pulses++;
        req_q <= sdram_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a miss at a, wait for the request, answer with word w.
    task automatic miss_fill(input logic [13:0] a, input logic [15:0] w, input bit same);
        fill_t e;
        int n;
        rom_cs = 1'b1;
        rom_addr = a;
        sb.push_back('{a[13:1], w});
        tick();
        n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", sdram_req, 1);
        e = sb.pop_front();
        chk("sdram_addr", sdram_addr, e.a);
        tick();
        chk("req_held", sdram_req, 1);
        sdram_ack = 1'b1;
        if (same) begin
            sdram_valid = 1'b1;
            sdram_data  = e.d;
        end
        tick();
        sdram_ack = 1'b0;
        sdram_valid = 1'b0;
        chk("req_drop", sdram_req, 0);
        if (!same) begin
            tick();
            sdram_valid = 1'b1;
            sdram_data  = e.d;
            tick();
            sdram_valid = 1'b0;
        end
        #1;
        chk("fill_ok", rom_ok, 1);
        chk("fill_data", rom_data, a[0] ? e.d[15:8] : e.d[7:0]);
    endtask

    initial begin
        fill_t e;
        int p0;
        #1;
        chk("rst_req", sdram_req, 0);
        chk("rst_addr", sdram_addr, 0);
        rom_cs = 1'b1;
        #1;
        chk("rst_ok", rom_ok, 0);
        rom_cs = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // cold miss
        miss_fill(14'h0001, 16'hA55A, 1'b0);

        // hit path, both bytes of one word
        miss_fill(14'h0010, 16'h1234, 1'b0);
        rom_addr = 14'h0011;
        #1;
        chk("hit_ok", rom_ok, 1);
        chk("hit_hi", rom_data, 8'h12);
        tick();
        chk("hit_noreq", sdram_req, 0);
        rom_addr = 14'h0010;
        #1;
        chk("hit_lo", rom_data, 8'h34);

        // flush in IDLE kills the hit immediately and afterwards
        flush = 1'b1;
        #1;
        chk("flush_comb", rom_ok, 0);
        tick();
        rom_cs = 1'b0;
        flush = 1'b0;
        rom_cs = 1'b1;
        #1;
        chk("flush_clear", rom_ok, 0);
        rom_cs = 1'b0;
        tick();

        // conflict on index 0
        miss_fill(14'h0000, 16'hBEEF, 1'b0);
        rom_addr = 14'h0010;
        #1;
        chk("conf_miss", rom_ok, 0);
        miss_fill(14'h0010, 16'h5678, 1'b0);
        rom_addr = 14'h0000;
        #1;
        chk("conf_evict", rom_ok, 0);
        miss_fill(14'h0000, 16'hBEEF, 1'b0);
        rom_cs = 1'b0;
        tick();

        // flush during WAIT discards the fill
        rom_cs = 1'b1;
        rom_addr = 14'h0100;
        sb.push_back('{13'h0080, 16'hCAFE});
        tick();
        e = sb.pop_front();
        chk("fl_addr", sdram_addr, e.a);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        flush = 1'b1;
        rom_addr = 14'h0222;
        tick();
        flush = 1'b0;
        rom_addr = 14'h0100;
        sdram_valid = 1'b1;
        sdram_data = e.d;
        tick();
        sdram_valid = 1'b0;
        #1;
        chk("fl_notvalid", rom_ok, 0);
        chk("fl_idle", sdram_req, 0);
        miss_fill(14'h0100, 16'hCAFE, 1'b0);
        rom_cs = 1'b0;
        tick();

        // ack+valid together in REQ
        p0 = req_pulses;
        miss_fill(14'h2006, 16'hC3D2, 1'b1);
        tick();
        tick();
        chk("same_noreq", sdram_req, 0);
        chk("same_pulses", req_pulses - p0, 1);
        rom_addr = 14'h2007;
        #1;
        chk("same_hi", rom_data, 8'hC3);
        rom_cs = 1'b0;
        tick();

        // reset during WAIT, late valid ignored
        rom_cs = 1'b1;
        rom_addr = 14'h3000;
        sb.push_back('{13'h1800, 16'h7777});
        tick();
        e = sb.pop_front();
        chk("rw_addr", sdram_addr, e.a);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rom_cs = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rw_req", sdram_req, 0);
        tick();
        rst_n = 1'b1;
        sdram_valid = 1'b1;
        sdram_data = e.d;
        tick();
        sdram_valid = 1'b0;
        rom_cs = 1'b1;
        #1;
        chk("rw_notvalid", rom_ok, 0);
        rom_addr = 14'h2006;
        #1;
        chk("rw_cleared", rom_ok, 0);
        rom_addr = 14'h3000;
        miss_fill(14'h3000, 16'h8899, 1'b0);
        rom_cs = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtdd_mcu_romfetch.md
JTDD_MCU_ROMFETCH -- requirements
Module: jtdd_mcu_romfetch

Purpose: MCU program-ROM fetch stage. Serves the MCU's rom_cs/rom_addr requests from a small direct-mapped word cache, refilled from SDRAM over a req/ack/valid handshake. Drives rom_data/rom_ok back to the MCU block.

Interface
REQ-001 Parameter IDX_W, default 3, SHALL set the cache index width: 2^IDX_W entries of 16-bit words.
REQ-002 Port clk, input, 1: single system clock; all logic SHALL be on its rising edge.
REQ-003 Port rst_n, input, 1: reset, SHALL be asynchronous and active-low.
REQ-004 Port rom_cs, input, 1: MCU ROM access strobe.
REQ-005 Port rom_addr, input, 14: MCU ROM byte address.
REQ-006 Port rom_data, output, 8: byte returned to the MCU.
REQ-007 Port rom_ok, output, 1: rom_data is valid for the current rom_addr.
REQ-008 Port flush, input, 1: invalidates the whole cache (ROM download or bank change).
REQ-009 Port sdram_req, output, 1: SDRAM read request.
REQ-010 Port sdram_addr, output, 13: SDRAM word address, equal to rom_addr[13:1] of the missed access.
REQ-011 Port sdram_ack, input, 1: SDRAM has accepted the request.
REQ-012 Port sdram_valid, input, 1: sdram_data is valid for one cycle.
REQ-013 Port sdram_data, input, 16: returned word; the low byte is the even address.

Function
REQ-014 Cache layout: index = rom_addr[IDX_W:1]; tag = rom_addr[13:IDX_W+1]; one valid bit per entry.
REQ-015 Hit definition: valid[index] && tag[index] equals the tag field of rom_addr.
REQ-016 rom_ok SHALL be combinational: rom_ok = rom_cs && hit && !flush. On a hit, data is available with zero added latency.
REQ-017 rom_data SHALL be the entry's low byte when rom_addr[0]=0 and its high byte when rom_addr[0]=1. Its value is don't-care while rom_ok=0.
REQ-018 FSM states are IDLE, REQ and WAIT. Reset state is IDLE.
REQ-019 IDLE -> REQ: when rom_cs && !hit && !flush. In the same edge, latch rom_addr[13:1] into sdram_addr.
REQ-020 In REQ, sdram_req SHALL be 1 and sdram_addr SHALL be held. On sdram_ack, go to WAIT, and sdram_req SHALL be 0 from the next cycle.
REQ-021 In WAIT, on sdram_valid: write sdram_data and the tag into the entry selected by the latched address, set its valid bit, and go to IDLE. The hit is visible on the following cycle, giving a miss latency of 2 + SDRAM latency cycles.
REQ-022 If sdram_ack and sdram_valid are asserted in the same cycle while in REQ, the fill SHALL complete directly and the FSM SHALL go to IDLE.
REQ-023 If rom_addr or rom_cs changes during REQ or WAIT, the fill SHALL still complete for the latched address. No new request is issued until IDLE.
REQ-024 flush SHALL clear every valid bit on the same edge.
REQ-025 If flush is asserted in REQ or WAIT, a discard flag is set. The returning fill SHALL not be written, and the FSM SHALL still finish the handshake and return to IDLE.
REQ-026 If flush and sdram_valid occur in the same cycle, the flush wins: no entry is left valid.
REQ-027 sdram_req SHALL never be asserted outside REQ. At most one request is outstanding at any time.
REQ-028 Index wrap-around: a fill SHALL overwrite the entry unconditionally, with no replacement policy.

Reset
REQ-029 While rst_n=0: FSM in IDLE, all valid bits 0, discard flag 0, sdram_req=0, sdram_addr=0, rom_ok=0.
REQ-030 Reset asserted mid-fill SHALL abandon the transaction. A late sdram_valid after reset SHALL be ignored, because the FSM is in IDLE.

Verification
REQ-031 Cold miss: after reset, rom_cs=1, rom_addr=14'h0001; SDRAM acks at cycle 2 and returns 16'hA55A at cycle 4 -> sdram_addr=13'h0000, rom_ok=1 and rom_data=8'hA5 on the cycle after valid.
REQ-032 Hit path: filled word 16'h1234 at rom_addr 14'h0010, then access 14'h0010 and 14'h0011 -> rom_ok=1 the same cycle, rom_data 8'h34 then 8'h12, sdram_req stays 0.
REQ-033 Conflict: fill 14'h0000, then access 14'h0010 (same index, IDX_W=3) -> miss, sdram_addr=13'h0008; afterwards 14'h0000 misses again.
REQ-034 Flush mid-fill: flush pulses during WAIT for 14'h0100; data returns -> entry not valid, FSM in IDLE, repeating the access refetches.
REQ-035 Simultaneous ack+valid in REQ -> entry written and FSM in IDLE in one cycle, with exactly one sdram_req pulse.
REQ-036 Reset during WAIT, then sdram_valid pulses after rst_n rises -> no entry valid, rom_ok=0, and the next miss issues a fresh request.
